// File: rtl/cpld_io_pkg.sv
// Shared constants and helpers for the peripheral-CPLD serial master.
// Holds the board defaults, the navigation button order and the slot timing helpers.
package cpld_io_pkg;

  // Board defaults
  localparam int unsigned DefFrameBits = 16;
  localparam int unsigned DefNavLsb    = 8;
  localparam int unsigned DefNavBits   = 5;

  // Width of each per-button debounce counter
  localparam int unsigned DebCntW = 4;

  // Button order within the nav field, starting at NAV_LSB
  typedef enum logic [2:0] {
    NavUp     = 3'd0,
    NavDown   = 3'd1,
    NavLeft   = 3'd2,
    NavRight  = 3'd3,
    NavSelect = 3'd4
  } nav_e;

  // Serial clock half-period in system clock cycles
  function automatic int unsigned half_period(input int unsigned div_log2);
    return 32'd1 << div_log2;
  endfunction

  // One slot is a full serial clock period
  function automatic int unsigned slot_len(input int unsigned div_log2);
    return 32'd2 << div_log2;
  endfunction

endpackage

// File: rtl/cpld_serial_io_nav_debounce.sv
// Per-button debounce.
// strobe_i : one pulse per received frame
// sample_i : button bit from that frame
// level_o  : accepted level, changes after DEB_FRAMES consecutive differing frames
// press_o  : one-cycle pulse on the cycle level_o rises
module nav_debounce
  import cpld_io_pkg::*;
#(
  parameter int unsigned DEB_FRAMES = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  input  logic sample_i,
  output logic level_o,
  output logic press_o
);

  logic [DebCntW-1:0] cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (strobe_i) begin
      if (sample_i != level_q) begin
        if (cnt_q + 1'b1 == DebCntW'(DEB_FRAMES)) begin
          cnt_d   = '0;
          level_d = sample_i;
          // Only a rising acceptance is a press
          press_d = sample_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/cpld_serial_io.sv
// Serial master for the board's peripheral CPLD.
// Each frame shifts FRAME_BITS of tx data out (bit 0 first), captures FRAME_BITS from the
// CPLD, then spends one slot with cpld_load high. Frames run back to back.
// clk_i, rst_i        : system clock, synchronous active-high reset
// tx_data_i           : word to send, snapshotted at frame start
// cpld_miso_i         : serial data from the CPLD
// cpld_mosi_o/clk_o/load_o : registered serial outputs, mutually aligned
// cpld_rstn_o         : ~rst_i, cpld_jtagen_o : tied low
// frame_start_o       : pulse on the snapshot cycle
// rx_data_o/rx_valid_o: last complete received frame and its update pulse
// nav_level_o/nav_press_o : debounced buttons and rising-edge pulses
module cpld_serial_io
  import cpld_io_pkg::*;
#(
  parameter int unsigned CLK_DIV_LOG2 = 12,
  parameter int unsigned FRAME_BITS   = DefFrameBits,
  parameter int unsigned NAV_BITS     = DefNavBits,
  parameter int unsigned NAV_LSB      = DefNavLsb,
  parameter int unsigned DEB_FRAMES   = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [FRAME_BITS-1:0] tx_data_i,
  input  logic                  cpld_miso_i,
  output logic                  cpld_mosi_o,
  output logic                  cpld_clk_o,
  output logic                  cpld_load_o,
  output logic                  cpld_rstn_o,
  output logic                  cpld_jtagen_o,
  output logic                  frame_start_o,
  output logic [FRAME_BITS-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic [NAV_BITS-1:0]   nav_level_o,
  output logic [NAV_BITS-1:0]   nav_press_o
);

  localparam int unsigned DivW  = CLK_DIV_LOG2 + 1;
  localparam int unsigned SlotW = $clog2(FRAME_BITS + 1);
  localparam int unsigned IdxW  = $clog2(FRAME_BITS);

  localparam logic [DivW-1:0]  DivMax   = DivW'(slot_len(CLK_DIV_LOG2) - 1);
  localparam logic [DivW-1:0]  DivHalf  = DivW'(half_period(CLK_DIV_LOG2));
  localparam logic [SlotW-1:0] LoadSlot = SlotW'(FRAME_BITS);

  logic [DivW-1:0]       div_q, div_d;
  logic [SlotW-1:0]      slot_q, slot_d;
  logic [FRAME_BITS-1:0] tx_shadow_q, tx_shadow_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  mosi_q, mosi_d;
  logic                  sclk_q, sclk_d;
  logic                  load_q, load_d;

  logic            in_load;
  logic            slot_end;
  logic            frame_end;
  logic            frame_start;
  logic [IdxW-1:0] idx;

  assign in_load   = (slot_q == LoadSlot);
  assign slot_end  = (div_q == DivMax);
  assign frame_end = in_load & slot_end;
  // Gated by reset so the pulse lands on the first cycle after release, not during reset
  assign frame_start = ~rst_i & (slot_q == '0) & (div_q == '0);
  // Only used outside the load slot, where slot_q < FRAME_BITS
  assign idx = slot_q[IdxW-1:0];

  always_comb begin
    div_d       = div_q + 1'b1;  // all-ones at slot end, so it wraps on its own
    slot_d      = slot_q;
    tx_shadow_d = tx_shadow_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;

    if (slot_end) begin
      slot_d = in_load ? '0 : slot_q + 1'b1;
    end
    if (frame_start) begin
      tx_shadow_d = tx_data_i;
    end
    // Last cycle of the high phase
    if (!in_load && slot_end) begin
      rx_shift_d[idx] = cpld_miso_i;
    end
    if (frame_end) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end

    // The shadow is loaded on this very edge, so slot 0 bit 0 comes straight from tx_data_i
    if (in_load) begin
      mosi_d = 1'b0;
    end else if (frame_start) begin
      mosi_d = tx_data_i[0];
    end else begin
      mosi_d = tx_shadow_q[idx];
    end
    sclk_d = ~in_load & (div_q >= DivHalf);
    load_d = in_load;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q       <= '0;
      slot_q      <= '0;
      tx_shadow_q <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      mosi_q      <= 1'b0;
      sclk_q      <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      slot_q      <= slot_d;
      tx_shadow_q <= tx_shadow_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      mosi_q      <= mosi_d;
      sclk_q      <= sclk_d;
      load_q      <= load_d;
    end
  end

  // Strobed with the same edge that updates rx_data, using the word about to be published
  for (genvar j = 0; j < NAV_BITS; j++) begin : g_nav
    nav_debounce #(
      .DEB_FRAMES(DEB_FRAMES)
    ) u_nav_debounce (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .strobe_i(frame_end),
      .sample_i(rx_shift_q[NAV_LSB + j]),
      .level_o (nav_level_o[j]),
      .press_o (nav_press_o[j])
    );
  end

  assign cpld_mosi_o   = mosi_q;
  assign cpld_clk_o    = sclk_q;
  assign cpld_load_o   = load_q;
  assign cpld_rstn_o   = ~rst_i;
  assign cpld_jtagen_o = 1'b0;
  assign frame_start_o = frame_start;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;

endmodule

// File: doc/cpld_serial_io.md
Name: cpld_serial_io

Overview:
- Parametrised serial master for the board's peripheral CPLD, the successor to the fixed 16-slot input controller.
- Each frame shifts FRAME_BITS of display/LED data out on cpld_mosi, captures FRAME_BITS back from cpld_miso, then issues one load slot.
- Adds a transmit snapshot, a frame-complete handshake, a per-button debounce and one-cycle press pulses.
- Display encoding and LED policy stay upstream; this block only moves bits.

Parameters:
- CLK_DIV_LOG2, 12, serial half-period = 2^CLK_DIV_LOG2 clk cycles.
- FRAME_BITS, 16, data slots per frame (2..64).
- NAV_BITS, 5, number of button inputs extracted from the received frame.
- NAV_LSB, 8, index of the first button bit within the received frame (NAV_LSB+NAV_BITS <= FRAME_BITS).
- DEB_FRAMES, 3, consecutive identical frames required to accept a button level (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  FRAME_BITS  word to shift out; bit 0 goes first
- cpld_miso  in  1  serial data from the CPLD
- cpld_mosi  out  1  serial data to the CPLD
- cpld_clk  out  1  serial clock
- cpld_load  out  1  latch strobe, high for the whole load slot
- cpld_rstn  out  1  = ~rst (combinational)
- cpld_jtagen  out  1  constant 0
- frame_start  out  1  one-cycle pulse on the cycle tx_data is snapshotted
- rx_data  out  FRAME_BITS  last complete received frame
- rx_valid  out  1  one-cycle pulse when rx_data updates
- nav_level  out  NAV_BITS  debounced button levels
- nav_press  out  NAV_BITS  one-cycle pulse per debounced 0->1 transition

Behaviour:
- Reset values: all registered outputs 0, rx_data 0, nav_* 0. The slot counter, divider and debounce counters also reset to 0.
- Reset applies on any cycle. A frame in progress is abandoned, and no rx_valid is produced for it.
- Divider: div_cnt counts 0..2^(CLK_DIV_LOG2+1)-1. One slot = 2^(CLK_DIV_LOG2+1) cycles. Slots are numbered 0..FRAME_BITS; slot FRAME_BITS is the load slot.
- Frame start: first cycle of slot 0, including the first cycle after reset deasserts.
  - tx_data is copied into tx_shadow.
  - frame_start pulses.
  - tx_data changes mid-frame have no effect on the current frame.
- Data slot i:
  - cpld_mosi = tx_shadow[i] for the whole slot.
  - cpld_clk = div_cnt MSB: low for the first half-slot, high for the second.
  - cpld_miso is sampled into rx_shift[i] on the last cycle of the high phase.
- Load slot: cpld_clk held 0, cpld_load = 1, cpld_mosi = 0.
  - On the last cycle of the load slot, rx_data <= rx_shift and rx_valid pulses.
  - The next cycle is slot 0 of the next frame; there are no idle gaps.
- Output timing: cpld_mosi, cpld_clk and cpld_load are registered, one cycle behind the internal counters. All three shift together, so skew between them is 0.
- Debounce (per button j), evaluated on each rx_valid with sample s = rx_data[NAV_LSB+j]:
  - If s != nav_level[j]: deb_cnt[j] increments. When it reaches DEB_FRAMES, nav_level[j] <= s and deb_cnt[j] <= 0.
  - If s == nav_level[j]: deb_cnt[j] <= 0.
  - nav_press[j] pulses in the same cycle nav_level[j] goes 0->1. There is no pulse on 1->0.
- Simultaneous button changes are handled independently per bit.
- Debounce latency after a stable input change is DEB_FRAMES frames. DEB_FRAMES=1 accepts the first differing frame.
- Widths: div_cnt has CLK_DIV_LOG2+1 bits. The slot counter has $clog2(FRAME_BITS+1) bits and wraps from FRAME_BITS to 0. deb_cnt has 4 bits.

Decomposition:
- Package cpld_io_pkg holds:
  - slot/phase helper functions (half-period, slot length);
  - the default board constants: FRAME_BITS=16, NAV_LSB=8, and the nav bit order up, down, left, right, select.
- One natural sub-module: nav_debounce. It is instantiated per button, takes sample/strobe in and produces level/press out.
- The shift engine stays in the top module.

Test Plan (CLK_DIV_LOG2=2, FRAME_BITS=16, DEB_FRAMES=3: slot = 8 clk, frame = 136 clk):
- Shift-out order: release rst, hold tx_data=16'hA5C3.
  - cpld_mosi over slots 0..15 reads 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - cpld_load is high for exactly 8 clk after slot 15; frame_start repeats every 136 clk.
- Loopback: cpld_miso driven from cpld_mosi with tx_data=16'h1234 -> rx_data=16'h1234 with rx_valid on the last load-slot cycle.
- Snapshot: change tx_data from 16'h00FF to 16'hFF00 during slot 5 -> current frame still shifts 16'h00FF; the next frame shifts 16'hFF00.
- Debounce/press: hold rx bit 8 (up) = 1 for 2 frames then 0 -> no nav_press.
  - Hold it = 1 for 3 frames -> nav_level[0]=1 and a single 1-cycle nav_press[0] at the 3rd rx_valid.
  - Releasing it after 3 frames gives nav_level[0]=0 and no press pulse.
- Reset mid-frame: assert rst for 1 clk during slot 9.
  - Outputs are 0 in the next cycle; no rx_valid for the abandoned frame.
  - frame_start occurs on the first cycle after deassertion; nav_level is cleared.
- Simultaneous buttons: bits 9 and 12 go to 1 in the same frame -> nav_press = 5'b10010 in one cycle after 3 frames.
